// File: rtl/train_pkg.sv
// Shared train-controller definitions: state encoding and the duration width.
// Pure constants and types, no latency, no flow control.
package train_pkg;

    localparam int DW_DEF = 13;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HOLD = ST_HOLD
    } timer_state_e;

    // Largest duration representable on a w-bit duration path.
    function automatic int max_ticks(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/phase_timer_tick_gen.sv
// Prescaler: strobes tick combinationally on the enabled cycle whose count is PRESCALE-1.
// Zero latency to tick; clear wins over enable; count frozen while enable is low.
module tick_gen #(
    parameter int PRESCALE = 50000,
    parameter int PW       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Phase countdown: loads a duration on start, counts it down in prescaled ticks, pulses expired.
// Expiry one cycle after edge E0+N*PRESCALE; each HOLD cycle adds one cycle; no backpressure.
module phase_timer
    import train_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int PRESCALE = 50000,
    parameter int PW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] tout_in,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    output logic          busy,
    output logic          expired,
    output logic [DW-1:0] remaining,
    output logic          tick
);

    timer_state_e  state_q,     state_d;
    logic [DW-1:0] remaining_q, remaining_d;
    logic          busy_q,      busy_d;
    logic          expired_q,   expired_d;
    logic          tick_q,      tick_d;

    logic          presc_clr;
    logic          presc_en;
    logic          presc_tick;

    // The HOLD->RUN edge advances the prescaler so a pause costs exactly its HOLD cycles.
    assign presc_clr = abort || start;
    assign presc_en  = !abort && !start && !pause &&
                       ((state_q == RUN) || (state_q == HOLD));

    tick_gen #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (presc_clr),
        .enable (presc_en),
        .tick   (presc_tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        expired_d   = 1'b0;
        tick_d      = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            remaining_d = '0;
            busy_d      = 1'b0;
        end else if (start) begin
            remaining_d = tout_in;
            if (tout_in != '0) begin
                state_d = RUN;
                busy_d  = 1'b1;
            end else begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                expired_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN, HOLD: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        if (presc_tick) begin
                            tick_d = 1'b1;
                            if (remaining_q <= DW'(1)) begin
                                state_d     = IDLE;
                                remaining_d = '0;
                                busy_d      = 1'b0;
                                expired_d   = 1'b1;
                            end else begin
                                remaining_d = remaining_q - DW'(1);
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and the unused encoding both settle to a clean IDLE.
                    state_d     = IDLE;
                    remaining_d = '0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
            tick_q      <= tick_d;
        end
    end

    assign busy      = busy_q;
    assign expired   = expired_q;
    assign remaining = remaining_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: PRESCALE=4 instance for timing cases, PRESCALE=1 for max duration.
module tb_phase_timer;

    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tout_in = '0;
    logic          start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic          busy, expired, tick;
    logic [DW-1:0] remaining;

    logic [DW-1:0] b_tout = '0;
    logic          b_start = 1'b0;
    logic          b_pause = 1'b0, b_abort = 1'b0;
    logic          b_busy, b_expired, b_tick;
    logic [DW-1:0] b_remaining;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    phase_timer #(.DW(DW), .PRESCALE(4), .PW(16)) dut (
        .clk(clk), .rst_n(rst_n), .tout_in(tout_in), .start(start), .pause(pause),
        .abort(abort), .busy(busy), .expired(expired), .remaining(remaining), .tick(tick)
    );

    phase_timer #(.DW(DW), .PRESCALE(1), .PW(16)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .tout_in(b_tout), .start(b_start), .pause(b_pause),
        .abort(b_abort), .busy(b_busy), .expired(b_expired), .remaining(b_remaining), .tick(b_tick)
    );

    typedef struct {
        string        nm;
        bit           st, pa, ab;
        int           tout;
        bit           by, ex, tk;
        int           rem;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string nm, bit st, bit pa, bit ab, int tout,
                                bit by, bit ex, int rem, bit tk);
        vec_t v;
        v.nm = nm; v.st = st; v.pa = pa; v.ab = ab; v.tout = tout;
        v.by = by; v.ex = ex; v.rem = rem; v.tk = tk;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input bit by, input bit ex, input int rem, input bit tk);
        chk({nm, ".busy"}, 32'(busy), 32'(by));
        chk({nm, ".expired"}, 32'(expired), 32'(ex));
        chk({nm, ".remaining"}, 32'(remaining), 32'(rem));
        chk({nm, ".tick"}, 32'(tick), 32'(tk));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ex_cnt;
        int first_ex;

        // Basic countdown, tout=3
        add("bas0",  1,0,0,3, 1,0,3,0);
        add("bas1",  0,0,0,0, 1,0,3,0);
        add("bas2",  0,0,0,0, 1,0,3,0);
        add("bas3",  0,0,0,0, 1,0,3,0);
        add("bas4",  0,0,0,0, 1,0,2,1);
        add("bas5",  0,0,0,0, 1,0,2,0);
        add("bas6",  0,0,0,0, 1,0,2,0);
        add("bas7",  0,0,0,0, 1,0,2,0);
        add("bas8",  0,0,0,0, 1,0,1,1);
        add("bas9",  0,0,0,0, 1,0,1,0);
        add("bas10", 0,0,0,0, 1,0,1,0);
        add("bas11", 0,0,0,0, 1,0,1,0);
        add("bas12", 0,0,0,0, 0,1,0,1);
        add("bas13", 0,0,0,0, 0,0,0,0);
        // Zero duration
        add("zero0", 1,0,0,0, 0,1,0,0);
        add("zero1", 0,0,0,0, 0,0,0,0);
        // Abort and start on the same edge
        add("sim0",  1,0,0,2, 1,0,2,0);
        add("sim1",  1,0,1,5, 0,0,0,0);
        add("sim2",  0,0,0,0, 0,0,0,0);
        // Pause for 5 cycles starting 2 cycles after start, tout=2
        add("pau0",  1,0,0,2, 1,0,2,0);
        add("pau1",  0,0,0,0, 1,0,2,0);
        add("pau2",  0,1,0,0, 1,0,2,0);
        add("pau3",  0,1,0,0, 1,0,2,0);
        add("pau4",  0,1,0,0, 1,0,2,0);
        add("pau5",  0,1,0,0, 1,0,2,0);
        add("pau6",  0,1,0,0, 1,0,2,0);
        add("pau7",  0,0,0,0, 1,0,2,0);
        add("pau8",  0,0,0,0, 1,0,2,0);
        add("pau9",  0,0,0,0, 1,0,1,1);
        add("pau10", 0,0,0,0, 1,0,1,0);
        add("pau11", 0,0,0,0, 1,0,1,0);
        add("pau12", 0,0,0,0, 1,0,1,0);
        add("pau13", 0,0,0,0, 0,1,0,1);
        add("pau14", 0,0,0,0, 0,0,0,0);

        // Reset
        rst_n = 1'b0;
        repeat (3) step();
        chk_all("rst_low", 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk_all("rst_rel", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            start   = tbl[i].st;
            pause   = tbl[i].pa;
            abort   = tbl[i].ab;
            tout_in = DW'(tbl[i].tout);
            step();
            chk_all(tbl[i].nm, tbl[i].by, tbl[i].ex, tbl[i].rem, tbl[i].tk);
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; tout_in = '0;

        // Abort at remaining=2
        start = 1'b1; tout_in = DW'(4);
        step();
        start = 1'b0;
        repeat (8) step();
        chk("abt.rem_before", 32'(remaining), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("abt.after", 0, 0, 0, 0);
        ex_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (expired) ex_cnt++;
        end
        chk("abt.no_expiry", 32'(ex_cnt), 32'd0);

        // Restart at remaining=1 with tout=5
        start = 1'b1; tout_in = DW'(2);
        step();
        start = 1'b0;
        repeat (4) step();
        chk("rs.rem_before", 32'(remaining), 32'd1);
        start = 1'b1; tout_in = DW'(5);
        step();
        start = 1'b0; tout_in = '0;
        chk("rs.rem_load", 32'(remaining), 32'd5);
        ex_cnt = 0; first_ex = -1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 3) chk("rs.presc_cleared", 32'(remaining), 32'd5);
            if (k == 4) chk("rs.first_dec", 32'(remaining), 32'd4);
            if (expired) begin
                ex_cnt++;
                if (first_ex < 0) first_ex = k;
            end
        end
        chk("rs.expiry_cycle", 32'(first_ex), 32'd20);
        chk("rs.expiry_count", 32'(ex_cnt), 32'd1);

        // Asynchronous reset mid-run at remaining=2
        start = 1'b1; tout_in = DW'(3);
        step();
        start = 1'b0;
        repeat (4) step();
        chk("rr.rem_before", 32'(remaining), 32'd2);
        chk("rr.tick_before", 32'(tick), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rr.async", 0, 0, 0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        ex_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (expired || busy) ex_cnt++;
        end
        chk("rr.quiet_after", 32'(ex_cnt), 32'd0);

        // Maximum duration on the PRESCALE=1 instance
        b_start = 1'b1; b_tout = DW'(8191);
        step();
        b_start = 1'b0; b_tout = '0;
        chk("max.rem_load", 32'(b_remaining), 32'd8191);
        ex_cnt = 0; first_ex = -1;
        for (int k = 1; k <= 8210; k++) begin
            step();
            if (k == 1) begin
                chk("max.first_tick", 32'(b_tick), 32'd1);
                chk("max.first_dec", 32'(b_remaining), 32'd8190);
            end
            if (b_expired) begin
                ex_cnt++;
                if (first_ex < 0) first_ex = k;
            end
        end
        chk("max.expiry_cycle", 32'(first_ex), 32'd8191);
        chk("max.expiry_count", 32'(ex_cnt), 32'd1);
        chk("max.rem_end", 32'(b_remaining), 32'd0);
        chk("max.busy_end", 32'(b_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
